dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the MEM-stage load/store interface. It accepts one
// word-addressed request at a time, waits a programmable number of cycles to
// emulate slow data memory, then performs a byte-enabled store or a word load.
// Misaligned and out-of-range accesses return an error and leave storage
// untouched.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between request acceptance and response (0..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (high only when idle)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     byte lane enables, bit i enables wdata[8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data; 0 for stores and for errors
//   rsp_err    access fault (misaligned or out of range)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Elaboration-time parameter checks.
    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
            $error("dmem_responder: WAIT_CYCLES must be in 0..255");
        end
        if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
        end
    endgenerate

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Request fields captured at acceptance; later input changes are ignored.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic          enter_resp;
    logic          do_write;
    logic [31:0]   rd_word;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign accept = req_valid & req_ready;

    // Address decode on the captured request.
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign acc_err      = misaligned | out_of_range;
    assign word_idx     = addr_q[AW+1:2];
    assign rd_word      = mem[word_idx];

    // The WAIT state counts WAIT_CYCLES down to zero and leaves on the
    // following edge, so it lasts WAIT_CYCLES+1 cycles and rsp_valid rises
    // exactly WAIT_CYCLES+1 edges after the accepting edge (1 edge when the
    // programmed wait is zero).
    assign enter_resp = (state_q == ST_WAIT) && (cnt_q == 8'd0);
    assign do_write   = enter_resp & we_q & ~acc_err;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RESP;
                    err_d   = acc_err;
                    // Stores and faults return zero; loads return the whole
                    // word regardless of the byte enables.
                    rdata_d = (acc_err || we_q) ? 32'd0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // NOTE: storage has no reset; clearing a RAM array costs a write port
    // sweep and real memories cannot do it. A reset only aborts the pending
    // transaction, which is enough because the write happens on RESP entry.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_responder: a driver issues requests and pushes
// the expected response (from a word-array model of memory) into a queue; a
// monitor compares every cycle the DUT presents a response. Two extra small
// instances measure latency for zero and four wait cycles.
module tb_dmem_responder;

    localparam time PERIOD = 10;
    localparam int  DEPTH  = 1024;
    localparam int  WAITC  = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Latency instances: index 0 has WAIT_CYCLES=0, index 1 has WAIT_CYCLES=4.
    logic        x_valid [2];
    logic        x_ready [2];
    logic        x_we [2];
    logic [31:0] x_addr [2];
    logic [31:0] x_wdata [2];
    logic [3:0]  x_be [2];
    logic        x_rsp_valid [2];
    logic        x_rsp_ready [2];
    logic [31:0] x_rdata [2];
    logic        x_rsp_err [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    time  acc_q[$];
    bit   bp_hold = 1'b0;
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(x_valid[0]), .req_ready(x_ready[0]), .req_we(x_we[0]),
        .req_addr(x_addr[0]), .req_wdata(x_wdata[0]), .req_be(x_be[0]),
        .rsp_valid(x_rsp_valid[0]), .rsp_ready(x_rsp_ready[0]),
        .rsp_rdata(x_rdata[0]), .rsp_err(x_rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst(rst),
        .req_valid(x_valid[1]), .req_ready(x_ready[1]), .req_we(x_we[1]),
        .req_addr(x_addr[1]), .req_wdata(x_wdata[1]), .req_be(x_be[1]),
        .rsp_valid(x_rsp_valid[1]), .rsp_ready(x_rsp_ready[1]),
        .rsp_rdata(x_rdata[1]), .rsp_err(x_rsp_err[1])
    );

    initial begin
        forever #(PERIOD / 2) clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Backpressure driver: random unless the bench is holding the response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Driver: applies the memory rules to the model, queues the expected
    // response and presents the request.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        exp_t e;
        int   guard;
        int   idx;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready timeout", 32'(req_ready), 32'd1);
            return;
        end
        e.err   = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
        e.rdata = 32'd0;
        if (!e.err) begin
            idx = int'({2'b00, a[31:2]});
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.rdata = model_mem[idx];
            end
        end
        exp_q.push_back(e);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        req_valid = 1'b1;
        @(posedge clk);
        acc_q.push_back($time);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble inputs after acceptance; the captured request must hold.
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("drain timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every cycle a response is presented against the
    // head of the expectation queue; pops on the handshake.
    initial begin
        bit   prev;
        exp_t e;
        time  t;
        int   lat;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else if (rsp_valid) begin
                if (!prev && acc_q.size() > 0) begin
                    t   = acc_q.pop_front();
                    lat = int'(($time - t) / PERIOD);
                    check("accept-to-rsp_valid latency", 32'(lat), 32'(WAITC + 1));
                end
                if (exp_q.size() == 0) begin
                    check("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("req_ready low while responding", 32'(req_ready), 32'd0);
                    if (rsp_ready) e = exp_q.pop_front();
                end
                prev = 1'b1;
            end else begin
                check("rsp_rdata idle zero", rsp_rdata, 32'd0);
                check("rsp_err idle zero", 32'(rsp_err), 32'd0);
                prev = 1'b0;
            end
        end
    end

    task automatic measure(input int i, input int want_lat);
        int n;
        @(negedge clk);
        check("x idle req_ready", 32'(x_ready[i]), 32'd1);
        x_we[i]        = 1'b1;
        x_addr[i]      = 32'h8;
        x_wdata[i]     = 32'hCAFE_0000 + 32'(i);
        x_be[i]        = 4'hF;
        x_rsp_ready[i] = 1'b1;
        x_valid[i]     = 1'b1;
        @(negedge clk);
        x_valid[i] = 1'b0;
        n = 0;
        while (!x_rsp_valid[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("x store latency", 32'(n), 32'(want_lat));
        check("x store rdata", x_rdata[i], 32'd0);
        @(negedge clk);
        x_we[i]    = 1'b0;
        x_be[i]    = 4'h0;
        x_valid[i] = 1'b1;
        @(negedge clk);
        x_valid[i] = 1'b0;
        n = 0;
        while (!x_rsp_valid[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("x load latency", 32'(n), 32'(want_lat));
        check("x load rdata", x_rdata[i], 32'hCAFE_0000 + 32'(i));
        check("x load err", 32'(x_rsp_err[i]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          g;
        for (int i = 0; i < 2; i++) begin
            x_valid[i] = 1'b0; x_we[i] = 1'b0; x_addr[i] = 32'd0;
            x_wdata[i] = 32'd0; x_be[i] = 4'd0; x_rsp_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        // Known contents for the window of words used below.
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 32'd0, 4'hF);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'h10, 32'd0, 4'h3);
        issue(1'b1, 32'h20, 32'h1122_3344, 4'hF);
        issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 32'h20, 32'd0, 4'h0);
        issue(1'b0, 32'h22, 32'd0, 4'hF);
        issue(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 32'h0, 32'd0, 4'hF);
        issue(1'b1, 32'h24, 32'h1234_5678, 4'h0);
        issue(1'b0, 32'h24, 32'd0, 4'hF);
        drain();

        // Backpressure: hold the response 5 cycles while a second request
        // waits on the input; it must not be taken.
        bp_hold = 1'b1;
        issue(1'b0, 32'h10, 32'd0, 4'hF);
        g = 0;
        while (!rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp rsp_valid reached", 32'(rsp_valid), 32'd1);
        req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            check("bp req_ready low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        bp_hold   = 1'b0;
        drain();
        issue(1'b0, 32'h14, 32'd0, 4'hF);
        drain();

        // Reset during WAIT of a store: store must be discarded.
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("store in flight req_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h30, 32'd0, 4'hF);
        drain();

        measure(0, 1);
        measure(1, 5);

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            a   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
            else if (sel == 1) a = a + 32'h1000;
            else if (sel == 2) a[31:28] = 4'($urandom_range(1, 15));
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
